// File: rtl/board_store.sv
// Board register file for dark chess: 32 squares of {color, type[2:0], state},
// an LFSR-driven Fisher-Yates shuffle at game start, and per-colour piece counts.
module board_store #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         wr_en,
   input  logic [4:0]   wr_addr,
   input  logic [4:0]   wr_piece,
   input  logic         init_start,
   output logic [159:0] board_output,
   output logic         init_busy,
   output logic         init_done,
   output logic [4:0]   red_count,
   output logic [4:0]   black_count,
   output logic         game_over
);

   localparam int unsigned NSQ = 32;
   localparam int unsigned PW  = 5;
   localparam int unsigned AW  = 5;
   localparam int unsigned SW  = 6;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PICK,
      SWAP,
      DONE
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] sq [NSQ];
   logic [15:0]   lfsr;
   logic [AW-1:0] idx_i;
   logic [AW-1:0] idx_j;
   logic [AW-1:0] mask;
   logic [AW-1:0] pick_j;
   logic          pick_ok;
   logic [SW-1:0] red_sum;
   logic [SW-1:0] black_sum;

   // Canonical covered piece for a square: low half red, high half black
   function automatic logic [PW-1:0] canon(input logic [AW-1:0] a);
      logic [2:0] t;
      case (a[3:0])
         4'd0:          t = 3'b111;
         4'd1, 4'd2:    t = 3'b110;
         4'd3, 4'd4:    t = 3'b101;
         4'd5, 4'd6:    t = 3'b100;
         4'd7, 4'd8:    t = 3'b011;
         4'd9, 4'd10:   t = 3'b010;
         default:       t = 3'b001;
      endcase
      return {a[4], t, 1'b0};
   endfunction

   // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   // Smallest all-ones mask covering the current shuffle index
   always_comb begin
      mask = 5'h01;
      if (idx_i[4])      mask = 5'h1F;
      else if (idx_i[3]) mask = 5'h0F;
      else if (idx_i[2]) mask = 5'h07;
      else if (idx_i[1]) mask = 5'h03;
      pick_j  = lfsr[4:0] & mask;
      pick_ok = (pick_j <= idx_i);
   end

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; out-of-range candidates are rejected and retried
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (init_start) state_next = LOAD;
         LOAD:    state_next = PICK;
         PICK:    if (pick_ok) state_next = SWAP;
         SWAP:    state_next = (idx_i == 5'd1) ? DONE : PICK;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs registered from the next state so they align with it
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         init_busy <= 1'b0;
         init_done <= 1'b0;
      end else begin
         init_busy <= (state_next != IDLE);
         init_done <= (state_next == DONE);
      end
   end

   // Square storage: player writes when idle, reload and swaps while shuffling
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int k = 0; k < NSQ; k++) sq[k] <= canon(AW'(k));
         idx_i <= '0;
         idx_j <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_en && !init_start) sq[wr_addr] <= wr_piece;
            end
            LOAD: begin
               for (int k = 0; k < NSQ; k++) sq[k] <= canon(AW'(k));
               idx_i <= 5'd31;
            end
            PICK: begin
               idx_j <= pick_j;
            end
            SWAP: begin
               sq[idx_i] <= sq[idx_j];
               sq[idx_j] <= sq[idx_i];
               if (idx_i != 5'd1) idx_i <= idx_i - 5'd1;
            end
            default: ;
         endcase
      end
   end

   // Flatten squares onto the board bus
   always_comb begin
      board_output = '0;
      for (int k = 0; k < NSQ; k++) board_output[k*PW +: PW] = sq[k];
   end

   // Live pieces per colour (non-empty type field)
   always_comb begin
      red_sum   = '0;
      black_sum = '0;
      for (int k = 0; k < NSQ; k++) begin
         if (sq[k][3:1] != 3'b000) begin
            if (sq[k][4]) black_sum = black_sum + 6'd1;
            else          red_sum   = red_sum + 6'd1;
         end
      end
   end

   // Registered counts; a full board of one colour saturates at 31 so it never reads as zero
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         red_count   <= 5'd16;
         black_count <= 5'd16;
      end else begin
         red_count   <= red_sum[5]   ? 5'd31 : red_sum[4:0];
         black_count <= black_sum[5] ? 5'd31 : black_sum[4:0];
      end
   end

   // Game over once idle with one side wiped out
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         game_over <= 1'b0;
      end else begin
         game_over <= !init_busy && (red_count == 5'd0 || black_count == 5'd0);
      end
   end

endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed steps plus random writes
// checked against a square-array model of the board.
module tb_board_store;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         wr_en = 1'b0;
   logic [4:0]   wr_addr = '0;
   logic [4:0]   wr_piece = '0;
   logic         init_start = 1'b0;
   logic [159:0] board_output;
   logic         init_busy;
   logic         init_done;
   logic [4:0]   red_count;
   logic [4:0]   black_count;
   logic         game_over;

   board_store #(.SEED(16'hACE1)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_piece     (wr_piece),
      .init_start   (init_start),
      .board_output (board_output),
      .init_busy    (init_busy),
      .init_done    (init_done),
      .red_count    (red_count),
      .black_count  (black_count),
      .game_over    (game_over)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passes = 0;
   logic [4:0] mdl [32];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Starting army for a square: king, 2 queens, 2 bishops, 2 rooks, 2 knights, 2 cannons, 5 soldiers
   function automatic logic [4:0] canon_code(input int s);
      int kind [16] = '{7, 6, 6, 5, 5, 4, 4, 3, 3, 2, 2, 1, 1, 1, 1, 1};
      logic [2:0] t;
      logic       c;
      t = 3'(kind[s % 16]);
      c = (s >= 16);
      return {c, t, 1'b0};
   endfunction

   function automatic logic [4:0] dsq(input int s);
      return board_output[s*5 +: 5];
   endfunction

   function automatic logic [159:0] pack_mdl();
      logic [159:0] v;
      v = '0;
      for (int s = 0; s < 32; s++) v[s*5 +: 5] = mdl[s];
      return v;
   endfunction

   function automatic int model_count(input bit black);
      int n;
      n = 0;
      for (int s = 0; s < 32; s++)
         if (mdl[s][3:1] != 3'b000 && mdl[s][4] == black) n++;
      return (n > 31) ? 31 : n;
   endfunction

   task automatic mdl_canon();
      for (int s = 0; s < 32; s++) mdl[s] = canon_code(s);
   endtask

   initial begin
      int er, eb;
      int done_cnt, busy_cnt, nd, nc;
      bit finished;

      // Reset state
      mdl_canon();
      step(); step(); step();
      RESET = 1'b0;
      chk("rst_sq0", 160'(dsq(0)), 160'(5'h0E));
      chk("rst_sq15", 160'(dsq(15)), 160'(5'h02));
      chk("rst_sq16", 160'(dsq(16)), 160'(5'h1E));
      chk("rst_sq31", 160'(dsq(31)), 160'(5'h12));
      chk("rst_board", board_output, pack_mdl());
      chk("rst_red", 160'(red_count), 160'(16));
      chk("rst_black", 160'(black_count), 160'(16));
      chk("rst_busy", 160'(init_busy), 160'(0));
      chk("rst_done", 160'(init_done), 160'(0));
      chk("rst_gameover", 160'(game_over), 160'(0));

      // Erase sq0, then write sq9; counts lag the squares by one edge
      wr_en = 1'b1; wr_addr = 5'd0; wr_piece = 5'h00; mdl[0] = 5'h00;
      step();
      chk("erase_sq0", 160'(dsq(0)), 160'(5'h00));
      chk("erase_red_lag", 160'(red_count), 160'(16));
      wr_addr = 5'd9; wr_piece = 5'h17; mdl[9] = 5'h17;
      step();
      chk("write_sq9", 160'(dsq(9)), 160'(5'h17));
      chk("erase_red_15", 160'(red_count), 160'(15));
      wr_en = 1'b0;
      step();
      chk("sq9_red", 160'(red_count), 160'(model_count(1'b0)));
      chk("sq9_black", 160'(black_count), 160'(model_count(1'b1)));

      // Random idle writes against the model
      for (int n = 0; n < 40; n++) begin
         er = model_count(1'b0);
         eb = model_count(1'b1);
         wr_en    = ($urandom_range(0, 3) != 0);
         wr_addr  = 5'($urandom_range(0, 31));
         wr_piece = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
         if (wr_en) mdl[wr_addr] = wr_piece;
         step();
         chk("rand_board", board_output, pack_mdl());
         chk("rand_red", 160'(red_count), 160'(er));
         chk("rand_black", 160'(black_count), 160'(eb));
      end
      wr_en = 1'b0;

      // Fresh board, then wipe out black
      #2 RESET = 1'b1;
      step();
      RESET = 1'b0;
      mdl_canon();
      chk("rst2_board", board_output, pack_mdl());
      for (int s = 16; s < 32; s++) begin
         wr_en = 1'b1; wr_addr = 5'(s); wr_piece = 5'h00; mdl[s] = 5'h00;
         step();
      end
      wr_en = 1'b0;
      chk("wipe_board", board_output, pack_mdl());
      step();
      chk("wipe_black", 160'(black_count), 160'(0));
      chk("wipe_red", 160'(red_count), 160'(16));
      step();
      chk("wipe_gameover", 160'(game_over), 160'(1));

      // Shuffle; a write coinciding with init_start is dropped, writes while busy ignored
      wr_en = 1'b1; wr_addr = 5'd3; wr_piece = 5'h1F; init_start = 1'b1;
      step();
      init_start = 1'b0;
      chk("start_busy", 160'(init_busy), 160'(1));
      chk("start_drop_write", 160'(dsq(3)), 160'(5'h0A));
      done_cnt = 0;
      busy_cnt = 1;
      finished = 1'b0;
      for (int c = 0; c < 3000 && !finished; c++) begin
         wr_en = 1'($urandom_range(0, 1));
         step();
         if (c == 0) chk("busy_clears_gameover", 160'(game_over), 160'(0));
         if (init_done) done_cnt++;
         if (init_busy) busy_cnt++;
         else finished = 1'b1;
      end
      wr_en = 1'b0;
      chk("shuffle_finished", 160'(finished), 160'(1));
      chk("shuffle_done_pulses", 160'(done_cnt), 160'(1));
      chk("shuffle_latency_ge64", 160'(busy_cnt >= 64), 160'(1));
      for (int code = 0; code < 32; code++) begin
         nd = 0;
         nc = 0;
         for (int s = 0; s < 32; s++) begin
            if (dsq(s) == 5'(code)) nd++;
            if (canon_code(s) == 5'(code)) nc++;
         end
         chk($sformatf("perm_code_%0h", code), 160'(nd), 160'(nc));
      end
      chk("shuffle_red", 160'(red_count), 160'(16));
      chk("shuffle_black", 160'(black_count), 160'(16));
      step();
      chk("shuffle_gameover", 160'(game_over), 160'(0));
      chk("shuffle_done_low", 160'(init_done), 160'(0));

      // Reset 20 cycles into a shuffle
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      repeat (19) step();
      chk("mid_busy", 160'(init_busy), 160'(1));
      #2 RESET = 1'b1;
      #1;
      mdl_canon();
      chk("abort_board", board_output, pack_mdl());
      chk("abort_busy", 160'(init_busy), 160'(0));
      chk("abort_done", 160'(init_done), 160'(0));
      step(); step();
      RESET = 1'b0;
      done_cnt = 0;
      busy_cnt = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (init_done) done_cnt++;
         if (init_busy) busy_cnt++;
      end
      chk("abort_no_done", 160'(done_cnt), 160'(0));
      chk("abort_stay_idle", 160'(busy_cnt), 160'(0));
      chk("abort_board_held", board_output, pack_mdl());
      chk("abort_red", 160'(red_count), 160'(16));
      chk("abort_black", 160'(black_count), 160'(16));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
